tile_fb_renderer: RTL and testbench
===================================

# tile_fb_renderer

Tile framebuffer and pixel renderer between the VGA sync generator and the VGA porch stage. Game logic writes 1-bit tiles into a GAME_WIDTH × GAME_HEIGHT on-chip bitmap through a valid/ready port. The render side converts the sync generator's column/row counts into tile addresses and reads the bitmap. It emits registered RGB plus HSync/VSync delayed to match, and raises a per-frame tick for the game logic.

## Interface
- GAME_WIDTH, 40, tiles per row
- GAME_HEIGHT, 30, tiles per column
- TILE_SHIFT, 4, log2 of tile size in pixels (16×16 tiles)
- VIDEO_WIDTH, 3, bits per colour channel
- ACTIVE_COLS, 640, visible pixel columns
- ACTIVE_ROWS, 480, visible pixel rows
- i_Clk  in  1  pixel clock; the only clock
- i_Rst  in  1  reset, asynchronous, active-high
- i_HSync, i_VSync  in  1 each  sync from sync generator, active-low
- i_Col_Count, i_Row_Count  in  10 each  current pixel column/row
- i_Wr_Valid  in  1  tile write request
- o_Wr_Ready  out  1  write accepted when i_Wr_Valid && o_Wr_Ready at rising edge
- i_Wr_X  in  6  tile column
- i_Wr_Y  in  5  tile row
- i_Wr_Data  in  1  tile value (1 = foreground)
- i_Clear  in  1  request to zero the whole bitmap
- o_Busy  out  1  clear sweep in progress
- o_Frame_Start  out  1  one-cycle pulse at start of vertical blanking
- o_HSync, o_VSync  out  1 each  syncs delayed 2 cycles
- o_Red, o_Grn, o_Blu  out  VIDEO_WIDTH each  pixel colour, 2-cycle latency

## Operation
- Bitmap has GAME_WIDTH*GAME_HEIGHT bits and is not reset. Address = Y*GAME_WIDTH + X.
- Write side FSM:
  - States: CLEAR, IDLE.
  - Reset enters CLEAR with clear address 0.
  - CLEAR writes 0 to one address per cycle, from 0 to N-1 where N = GAME_WIDTH*GAME_HEIGHT (1200 by default). After address N-1 it goes to IDLE.
  - IDLE plus i_Clear goes to CLEAR with address 0.
- o_Busy = (state == CLEAR).
- o_Wr_Ready = (state == IDLE) && !i_Clear. It is combinational, so a clear takes priority over a same-cycle write.
- i_Clear while in CLEAR is ignored; the sweep does not restart.
- Accepted writes with X ≥ GAME_WIDTH or Y ≥ GAME_HEIGHT are dropped. No memory change; the handshake still completes.
- Render pipeline:
  - Stage 1 registers: tile address from count[9:TILE_SHIFT], active flag (col < ACTIVE_COLS && row < ACTIVE_ROWS), in-grid flag (tile X/Y in range), both syncs.
  - Stage 2 registers: bitmap read data, the flags, the syncs.
  - Colour in stage 2:
    - inactive → 0
    - active and out of grid, or bit 0 → background red (R=all ones, G=B=0)
    - bit 1 → white (all channels all ones)
- A read and a write to the same address in the same cycle: the read returns the old value.
- o_Frame_Start is registered and pulses for 1 cycle, 1 cycle after inputs show row == ACTIVE_ROWS && col == 0.

## Timing
- Reset values:
  - o_HSync = o_VSync = 1
  - RGB = 0
  - o_Frame_Start = 0
  - o_Busy = 1 and o_Wr_Ready = 0 while reset is asserted and afterwards until the sweep completes
- Latency:
  - counts/syncs at edge k → RGB/syncs at edge k+2
  - write accepted at edge k → visible to a read sampled at edge k+1
- Clear sweep lasts exactly N cycles. o_Busy falls on the edge after address N-1 is written; o_Wr_Ready rises with it.
- Reset asserted mid-sweep or mid-frame: pipeline and FSM return immediately to reset values, and the sweep restarts from 0 after release.

## Configuration
- TILE_GRID_EN defined: active pixels with col[TILE_SHIFT-1:0] == 0 or row[TILE_SHIFT-1:0] == 0 output blue (B = all ones, R = G = 0). This overrides tile colour. Same 2-cycle latency.
- Undefined: no grid logic; colour follows tile and background rules only.

## Test plan
- Release reset → o_Busy high for exactly 1200 cycles, o_Wr_Ready 0 throughout; every visible pixel of the next frame outputs R=7, G=0, B=0.
- Write X=3, Y=2, data 1 → pixels col 48–63, row 32–47 output 7/7/7 two cycles after their counts; col 64 outputs 7/0/0.
- i_Clear and i_Wr_Valid in the same IDLE cycle → o_Wr_Ready 0, write not taken, sweep runs 1200 cycles, bitmap all 0.
- Write X=45, Y=0 → handshake completes, and no pixel of the next frame changes; counts col 700, row 100 → RGB 0 with HSync passed through delayed by 2.
- Counts row 480, col 0 → o_Frame_Start high for exactly 1 cycle at the next edge. Assert i_Rst during a sweep at address 600 → outputs return to reset values and a fresh 1200-cycle sweep follows release.
- With TILE_GRID_EN: col 16, row 5 → 0/0/7 even where tile bit is 1.

Source files
------------

// File: rtl/tile_fb_renderer.sv
// tile_fb_renderer
//   Tile framebuffer and pixel renderer sitting between the VGA sync generator
//   and the porch stage. Game logic writes 1-bit tiles into a GAME_WIDTH x
//   GAME_HEIGHT bitmap over a valid/ready port; the render side maps the
//   incoming column/row counts onto tiles and emits registered RGB with the
//   syncs delayed to line up.
//
// Ports
//   i_Clk, i_Rst                pixel clock, async active-high reset
//   i_HSync, i_VSync            active-low syncs from the sync generator
//   i_Col_Count, i_Row_Count    current pixel column / row
//   i_Wr_Valid, o_Wr_Ready      tile write handshake
//   i_Wr_X, i_Wr_Y, i_Wr_Data   tile coordinate and value (1 = foreground)
//   i_Clear, o_Busy             start / status of a full bitmap clear sweep
//   o_Frame_Start               1-cycle pulse at the start of vertical blanking
//   o_HSync, o_VSync            syncs delayed 2 cycles
//   o_Red, o_Grn, o_Blu         pixel colour, 2-cycle latency from the counts
//
// Build option
//   TILE_GRID_EN  when defined, the first pixel row/column of every tile is
//                 drawn blue on top of the tile colour.

module tile_fb_renderer #(
    parameter int GAME_WIDTH  = 40,
    parameter int GAME_HEIGHT = 30,
    parameter int TILE_SHIFT  = 4,
    parameter int VIDEO_WIDTH = 3,
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic                   i_HSync,
    input  logic                   i_VSync,
    input  logic [9:0]             i_Col_Count,
    input  logic [9:0]             i_Row_Count,
    input  logic                   i_Wr_Valid,
    output logic                   o_Wr_Ready,
    input  logic [5:0]             i_Wr_X,
    input  logic [4:0]             i_Wr_Y,
    input  logic                   i_Wr_Data,
    input  logic                   i_Clear,
    output logic                   o_Busy,
    output logic                   o_Frame_Start,
    output logic                   o_HSync,
    output logic                   o_VSync,
    output logic [VIDEO_WIDTH-1:0] o_Red,
    output logic [VIDEO_WIDTH-1:0] o_Grn,
    output logic [VIDEO_WIDTH-1:0] o_Blu
);

    localparam int N  = GAME_WIDTH * GAME_HEIGHT;
    localparam int AW = $clog2(N);
    localparam int TW = 10 - TILE_SHIFT;

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    // Priority: outside the visible area -> black, grid line -> blue,
    // foreground tile -> white, anything else visible -> background red.
    function automatic logic [3*VIDEO_WIDTH-1:0] pixel_colour(
        input logic act,
        input logic in_grid,
        input logic tile_bit,
        input logic grid_line
    );
        logic [VIDEO_WIDTH-1:0] ones;
        logic [VIDEO_WIDTH-1:0] zero;
        ones = '1;
        zero = '0;
        if (!act)                 return {zero, zero, zero};
        if (grid_line)            return {zero, zero, ones};
        if (in_grid && tile_bit)  return {ones, ones, ones};
        return {ones, zero, zero};
    endfunction

    state_t          state, state_nxt;
    logic [AW-1:0]   clr_addr, clr_addr_nxt;

    logic            wr_fire;
    logic            wr_in_grid;
    logic [AW-1:0]   wr_addr;

    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic            mem_wdata;
    logic            mem [0:N-1];

    logic [TW-1:0]   tile_x, tile_y;
    logic            pix_act, pix_in_grid, pix_line;
    logic [AW-1:0]   rd_addr;

    logic [AW-1:0]   addr_p1;
    logic            act_p1, grid_p1, line_p1, hs_p1, vs_p1;

    // Write-side FSM: a sweep zeroes one address per cycle, then idles.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state    <= S_CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= clr_addr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        case (state)
            S_CLEAR: begin
                if (clr_addr == AW'(N - 1)) begin
                    state_nxt    = S_IDLE;
                    clr_addr_nxt = '0;
                end else begin
                    clr_addr_nxt = clr_addr + 1'b1;
                end
            end
            S_IDLE: begin
                if (i_Clear) begin
                    state_nxt    = S_CLEAR;
                    clr_addr_nxt = '0;
                end
            end
            default: begin
                state_nxt    = S_CLEAR;
                clr_addr_nxt = '0;
            end
        endcase
    end

    assign o_Busy     = (state == S_CLEAR);
    // Combinational so a same-cycle clear request blocks the write.
    assign o_Wr_Ready = (state == S_IDLE) && !i_Clear;
    assign wr_fire    = i_Wr_Valid && o_Wr_Ready;

    // Off-grid writes still complete the handshake but never touch memory.
    assign wr_in_grid = (int'(i_Wr_X) < GAME_WIDTH) && (int'(i_Wr_Y) < GAME_HEIGHT);
    assign wr_addr    = AW'(int'(i_Wr_Y) * GAME_WIDTH + int'(i_Wr_X));

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_addr;
        mem_wdata = 1'b0;
        if (o_Busy) begin
            mem_we = 1'b1;
        end else if (wr_fire && wr_in_grid) begin
            mem_we    = 1'b1;
            mem_waddr = wr_addr;
            mem_wdata = i_Wr_Data;
        end
    end

    // Bitmap is deliberately not reset; the clear sweep initialises it.
    always_ff @(posedge i_Clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign tile_x      = i_Col_Count[9:TILE_SHIFT];
    assign tile_y      = i_Row_Count[9:TILE_SHIFT];
    assign pix_act     = (int'(i_Col_Count) < ACTIVE_COLS) && (int'(i_Row_Count) < ACTIVE_ROWS);
    assign pix_in_grid = (int'(tile_x) < GAME_WIDTH) && (int'(tile_y) < GAME_HEIGHT);
    // Off-grid pixels read address 0; their colour ignores the bit anyway.
    assign rd_addr     = pix_in_grid ? AW'(int'(tile_y) * GAME_WIDTH + int'(tile_x)) : '0;

`ifdef TILE_GRID_EN
    assign pix_line = (i_Col_Count[TILE_SHIFT-1:0] == '0) || (i_Row_Count[TILE_SHIFT-1:0] == '0);
`else
    assign pix_line = 1'b0;
`endif

    // ---- stage 1: tile address, flags, syncs ----
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            act_p1  <= 1'b0;
            grid_p1 <= 1'b0;
            line_p1 <= 1'b0;
            hs_p1   <= 1'b1;
            vs_p1   <= 1'b1;
        end else begin
            act_p1  <= pix_act;
            grid_p1 <= pix_in_grid;
            line_p1 <= pix_line;
            hs_p1   <= i_HSync;
            vs_p1   <= i_VSync;
        end
    end

    always_ff @(posedge i_Clk) begin
        addr_p1 <= rd_addr;
    end

    // ---- stage 2: bitmap read, colour, syncs ----
    // A write landing on the same edge is not seen here: the read returns the old bit.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_Red   <= '0;
            o_Grn   <= '0;
            o_Blu   <= '0;
            o_HSync <= 1'b1;
            o_VSync <= 1'b1;
        end else begin
            {o_Red, o_Grn, o_Blu} <= pixel_colour(act_p1, grid_p1, mem[addr_p1], line_p1);
            o_HSync <= hs_p1;
            o_VSync <= vs_p1;
        end
    end

    // Vertical blanking begins with the first pixel of the first invisible row.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_Frame_Start <= 1'b0;
        end else begin
            o_Frame_Start <= (i_Row_Count == 10'(ACTIVE_ROWS)) && (i_Col_Count == '0);
        end
    end

endmodule

// File: tb/tb_tile_fb_renderer.sv
module tb_tile_fb_renderer;

    localparam int NTILES = 1200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hsync = 1'b1, vsync = 1'b1;
    logic [9:0] col_c = 10'd700, row_c = 10'd100;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [5:0] wr_x = '0;
    logic [4:0] wr_y = '0;
    logic       wr_data = 1'b0;
    logic       clear = 1'b0;
    logic       busy, frame_start, o_hs, o_vs;
    logic [2:0] o_r, o_g, o_b;

    tile_fb_renderer dut (
        .i_Clk        (clk),
        .i_Rst        (rst),
        .i_HSync      (hsync),
        .i_VSync      (vsync),
        .i_Col_Count  (col_c),
        .i_Row_Count  (row_c),
        .i_Wr_Valid   (wr_valid),
        .o_Wr_Ready   (wr_ready),
        .i_Wr_X       (wr_x),
        .i_Wr_Y       (wr_y),
        .i_Wr_Data    (wr_data),
        .i_Clear      (clear),
        .o_Busy       (busy),
        .o_Frame_Start(frame_start),
        .o_HSync      (o_hs),
        .o_VSync      (o_vs),
        .o_Red        (o_r),
        .o_Grn        (o_g),
        .o_Blu        (o_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned due;
        logic [2:0]  r, g, b;
        logic        hs, vs;
        int          tag;
    } exp_t;

    typedef struct {
        int         col, row;
        logic       hs, vs;
        logic [2:0] r, g, b;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;

    // Scoreboard: each expected pixel is due two edges after its counts are driven.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            mon_e = sb.pop_front();
            checks++;
            if ({o_r, o_g, o_b, o_hs, o_vs} !== {mon_e.r, mon_e.g, mon_e.b, mon_e.hs, mon_e.vs}) begin
                errors++;
                $display("FAIL pixel tag=%0d got rgb=%0d/%0d/%0d hs=%b vs=%b want rgb=%0d/%0d/%0d hs=%b vs=%b",
                         mon_e.tag, o_r, o_g, o_b, o_hs, o_vs,
                         mon_e.r, mon_e.g, mon_e.b, mon_e.hs, mon_e.vs);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic set_idle();
        col_c = 10'd700;
        row_c = 10'd100;
        hsync = 1'b1;
        vsync = 1'b1;
    endtask

    task automatic pix(input int col, input int row, input logic hs, input logic vs,
                       input logic [2:0] r, input logic [2:0] g, input logic [2:0] b, input int tag);
        @(posedge clk);
        #1;
        col_c = 10'(col);
        row_c = 10'(row);
        hsync = hs;
        vsync = vs;
        sb.push_back('{cyc + 2, r, g, b, hs, vs, tag});
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", sb.size());
            sb.delete();
        end
        #1;
        set_idle();
    endtask

    task automatic scan(input int hx, input int hy, input int tag);
        for (int ty = 0; ty < 30; ty++) begin
            for (int tx = 0; tx < 40; tx++) begin
                if (tx == hx && ty == hy)
                    pix(tx * 16 + 5, ty * 16 + 9, 1'b1, 1'b1, 3'd7, 3'd7, 3'd7, tag);
                else
                    pix(tx * 16 + 5, ty * 16 + 9, 1'b1, 1'b1, 3'd7, 3'd0, 3'd0, tag);
            end
        end
        drain();
    endtask

    task automatic wr(input int x, input int y, input logic d, input string name);
        logic ok;
        @(posedge clk);
        #1;
        wr_valid = 1'b1;
        wr_x     = 6'(x);
        wr_y     = 5'(y);
        wr_data  = d;
        ok       = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (wr_ready) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        chk(name, 32'(ok), 32'd1);
    endtask

    task automatic count_busy(input int exp_n, input string name);
        int n;
        int rdy_hi;
        logic done;
        n = 0;
        rdy_hi = 0;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (busy) begin
                n++;
                if (wr_ready) rdy_hi++;
            end else begin
                done = 1'b1;
            end
        end
        chk({name, "_busy_len"}, 32'(n), 32'(exp_n));
        chk({name, "_ready_while_busy"}, 32'(rdy_hi), 32'd0);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_hsync"}, 32'(o_hs), 32'd1);
        chk({name, "_vsync"}, 32'(o_vs), 32'd1);
        chk({name, "_rgb"}, 32'({o_r, o_g, o_b}), 32'd0);
        chk({name, "_frame_start"}, 32'(frame_start), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd1);
        chk({name, "_ready"}, 32'(wr_ready), 32'd0);
    endtask

    vec_t vecs[12];

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{48,  32,  1'b1, 1'b1, 3'd7, 3'd7, 3'd7};
        vecs[1]  = '{63,  47,  1'b1, 1'b1, 3'd7, 3'd7, 3'd7};
        vecs[2]  = '{64,  32,  1'b1, 1'b1, 3'd7, 3'd0, 3'd0};
        vecs[3]  = '{47,  40,  1'b1, 1'b1, 3'd7, 3'd0, 3'd0};
        vecs[4]  = '{55,  48,  1'b1, 1'b1, 3'd7, 3'd0, 3'd0};
        vecs[5]  = '{700, 100, 1'b0, 1'b1, 3'd0, 3'd0, 3'd0};
        vecs[6]  = '{100, 500, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0};
        vecs[7]  = '{639, 479, 1'b1, 1'b1, 3'd7, 3'd0, 3'd0};
        vecs[8]  = '{640, 0,   1'b1, 1'b1, 3'd0, 3'd0, 3'd0};
        vecs[9]  = '{0,   0,   1'b1, 1'b1, 3'd7, 3'd0, 3'd0};
        vecs[10] = '{80,  16,  1'b1, 1'b1, 3'd7, 3'd0, 3'd0};
        vecs[11] = '{56,  40,  1'b0, 1'b0, 3'd7, 3'd7, 3'd7};
`ifdef TILE_GRID_EN
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].col < 640 && vecs[i].row < 480 &&
                (vecs[i].col % 16 == 0 || vecs[i].row % 16 == 0)) begin
                vecs[i].r = 3'd0;
                vecs[i].g = 3'd0;
                vecs[i].b = 3'd7;
            end
        end
`endif

        // Reset state, then the power-on sweep.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        count_busy(NTILES, "por");
        scan(-1, -1, 1);

        // One foreground tile, then the vector table around it.
        wr(3, 2, 1'b1, "wr_3_2_handshake");
        scan(3, 2, 2);

        // Out-of-range X: handshake completes, nothing changes (addr 45 alias is tile 5,1).
        wr(45, 0, 1'b1, "wr_45_0_handshake");
        for (int i = 0; i < 12; i++)
            pix(vecs[i].col, vecs[i].row, vecs[i].hs, vecs[i].vs,
                vecs[i].r, vecs[i].g, vecs[i].b, 100 + i);
        drain();
        scan(3, 2, 3);

`ifdef TILE_GRID_EN
        wr(1, 0, 1'b1, "wr_1_0_handshake");
        pix(16, 5, 1'b1, 1'b1, 3'd0, 3'd0, 3'd7, 200);
        pix(21, 5, 1'b1, 1'b1, 3'd7, 3'd7, 3'd7, 201);
        drain();
`endif

        // Frame start pulse.
        @(posedge clk);
        #1;
        col_c = 10'd0;
        row_c = 10'd480;
        @(negedge clk);
        chk("frame_start_before", 32'(frame_start), 32'd0);
        @(posedge clk);
        #1;
        col_c = 10'd1;
        @(negedge clk);
        chk("frame_start_pulse", 32'(frame_start), 32'd1);
        @(posedge clk);
        #1;
        set_idle();
        @(negedge clk);
        chk("frame_start_after", 32'(frame_start), 32'd0);

        // Clear and write in the same idle cycle: clear wins.
        @(posedge clk);
        #1;
        clear    = 1'b1;
        wr_valid = 1'b1;
        wr_x     = 6'd10;
        wr_y     = 5'd10;
        wr_data  = 1'b1;
        @(negedge clk);
        chk("clear_vs_write_ready", 32'(wr_ready), 32'd0);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        wr_valid = 1'b0;
        count_busy(NTILES, "clear");
        scan(-1, -1, 4);

        // Clear requests during a sweep are ignored.
        @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        count_busy(NTILES - 301, "clear_ignored");

        // Reset in the middle of a sweep (address 600) with a visible pixel in flight.
        @(posedge clk);
        #1;
        clear = 1'b1;
        col_c = 10'd100;
        row_c = 10'd100;
        hsync = 1'b0;
        vsync = 1'b0;
        @(posedge clk);
        #1;
        clear = 1'b0;
        repeat (600) @(posedge clk);
        #1;
        chk("pre_reset_red", 32'(o_r), 32'd7);
        chk("pre_reset_hsync", 32'(o_hs), 32'd0);
        rst = 1'b1;
        #1;
        chk_reset_vals("mid_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        set_idle();
        rst = 1'b0;
        count_busy(NTILES, "post_reset");
        scan(-1, -1, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
